// File: rtl/fetch_stage_if.sv
// Fetch stage bundle: imem req/gnt/rvalid bus, decode handshake, redirects.
// master = fetch side, slave = memory/decode/redirect side.
interface fetch_stage_if #(
  parameter int ADDR_SIZE  = 32,
  parameter int INSTR_SIZE = 32
);
  logic                  imem_req;
  logic [ADDR_SIZE-1:0]  imem_addr;
  logic                  imem_gnt;
  logic                  imem_rvalid;
  logic [INSTR_SIZE-1:0] imem_rdata;
  logic                  out_valid;
  logic [ADDR_SIZE-1:0]  out_pc;
  logic [INSTR_SIZE-1:0] out_instr;
  logic                  dec_ready;
  logic                  jump_valid;
  logic [ADDR_SIZE-1:0]  jump_addr;
  logic                  branch_valid;
  logic [ADDR_SIZE-1:0]  branch_addr;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output out_valid, out_pc, out_instr,
    input  dec_ready,
    input  jump_valid, jump_addr,
    input  branch_valid, branch_addr
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  out_valid, out_pc, out_instr,
    output dec_ready,
    output jump_valid, jump_addr,
    output branch_valid, branch_addr
  );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: single-outstanding imem fetch, instruction FIFO, redirects.
// Optional FETCH_PERF_CNT_EN adds perf_fetched/perf_redirects counters.
module fetch_stage #(
  parameter int ADDR_SIZE   = 32,
  parameter int INSTR_SIZE  = 32,
  parameter int QUEUE_DEPTH = 2,
  parameter logic [ADDR_SIZE-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic reset,
  fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_redirects
`endif
);
  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic [ADDR_SIZE-1:0]  pc;
    logic [INSTR_SIZE-1:0] instr;
  } entry_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_run;
  logic [ADDR_SIZE-1:0] r_pc;
  logic [ADDR_SIZE-1:0] w_pc_nxt;
  entry_t               r_q [QUEUE_DEPTH];
  logic [PW-1:0]        r_rd_ptr;
  logic [PW-1:0]        r_wr_ptr;
  logic [CW-1:0]        r_count;

  logic                 w_redirect;
  logic [ADDR_SIZE-1:0] w_raw_tgt;
  logic [ADDR_SIZE-1:0] w_target;
  logic                 w_empty;
  logic                 w_space;
  logic                 w_req;
  logic                 w_hs;
  logic                 w_push;
  logic                 w_pop;
  entry_t               w_head;

  assign w_redirect = bus.branch_valid | bus.jump_valid;
  assign w_raw_tgt  = bus.branch_valid ? bus.branch_addr
                                       : bus.jump_addr;
  assign w_target   = {w_raw_tgt[ADDR_SIZE-1:2], 2'b00};

  assign w_empty = (r_count == '0);
  assign w_space = (r_count < DEPTH_C);
  // r_run keeps imem_req low until the first edge after reset release
  assign w_req   = r_run && (r_state == S_REQ) && w_space;
  assign w_hs    = w_req && bus.imem_gnt;
  assign w_push  = (r_state == S_WAIT) && bus.imem_rvalid
                   && !w_redirect;
  assign w_pop   = !w_empty && bus.dec_ready && !w_redirect;
  assign w_head  = r_q[r_rd_ptr];

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = w_req ? r_pc : '0;
  assign bus.out_valid = !w_empty;
  assign bus.out_pc    = w_empty ? '0 : w_head.pc;
  assign bus.out_instr = w_empty ? '0 : w_head.instr;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    unique case (r_state)
      S_REQ: begin
        if (w_hs)
          w_state_nxt = w_redirect ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          w_state_nxt = S_REQ;
          w_pc_nxt    = r_pc + ADDR_SIZE'(4);
        end else if (w_redirect) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.imem_rvalid)
          w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_REQ;
    endcase
    if (w_redirect)
      w_pc_nxt = w_target;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_REQ;
      r_run   <= 1'b0;
      r_pc    <= {RESET_PC[ADDR_SIZE-1:2], 2'b00};
    end else begin
      r_state <= w_state_nxt;
      r_run   <= 1'b1;
      r_pc    <= w_pc_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++)
        r_q[i] <= '0;
    end else if (w_redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_q[r_wr_ptr] <= '{pc: r_pc, instr: bus.imem_rdata};
        r_wr_ptr      <= r_wr_ptr + PW'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched   <= '0;
      perf_redirects <= '0;
    end else begin
      if (w_push)
        perf_fetched <= perf_fetched + 32'd1;
      if (w_redirect)
        perf_redirects <= perf_redirects + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 1-cycle-latency imem responder.
// Optional FETCH_PERF_CNT_EN ports are hooked up when the macro is set.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if #(.ADDR_SIZE(32), .INSTR_SIZE(32)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_redirects;
`endif

  fetch_stage #(
    .ADDR_SIZE(32),
    .INSTR_SIZE(32),
    .QUEUE_DEPTH(2),
    .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(bus.master)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_redirects(perf_redirects)
`endif
  );

  int errors = 0;
  int checks = 0;
  logic        pending;
  logic        stall_rsp;
  logic [31:0] pend_addr;
  logic [31:0] grants [$];
  logic [31:0] got_pc [$];
  logic [31:0] got_ins [$];

  // memory image: each word encodes its own address
  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // one clock: log handshakes, advance, drive imem response
  task automatic step();
    logic hs;
    logic pop;
    logic [31:0] a;
    hs  = bus.imem_req && bus.imem_gnt;
    a   = bus.imem_addr;
    pop = bus.out_valid && bus.dec_ready
          && !bus.jump_valid && !bus.branch_valid;
    if (pop) begin
      got_pc.push_back(bus.out_pc);
      got_ins.push_back(bus.out_instr);
    end
    if (hs) grants.push_back(a);
    @(posedge clk);
    #1;
    if (hs) begin
      pending   = 1'b1;
      pend_addr = a;
    end
    if (pending && !stall_rsp) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = ins_of(pend_addr);
      pending = 1'b0;
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
    end
  endtask

  task automatic init_inputs();
    bus.imem_gnt     = 1'b1;
    bus.imem_rvalid  = 1'b0;
    bus.imem_rdata   = '0;
    bus.dec_ready    = 1'b1;
    bus.jump_valid   = 1'b0;
    bus.jump_addr    = '0;
    bus.branch_valid = 1'b0;
    bus.branch_addr  = '0;
    pending   = 1'b0;
    stall_rsp = 1'b0;
    pend_addr = '0;
    grants.delete();
    got_pc.delete();
    got_ins.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    init_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    init_inputs();
    @(posedge clk);
    #1;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rst_imem: req=%b addr=%h want 0/0",
               bus.imem_req, bus.imem_addr);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0
        || bus.out_instr !== 32'h0) begin
      errors++;
      $display("FAIL rst_out: v=%b pc=%h ins=%h want 0",
               bus.out_valid, bus.out_pc, bus.out_instr);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL rel_req: got %b want 0", bus.imem_req);
    end
    step();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h want 1/0",
               bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_stream();
    do_reset();
    step();
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL early_valid: got %b want 0", bus.out_valid);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0
        || bus.out_instr !== 32'hC0DE0000) begin
      errors++;
      $display("FAIL first_out: v=%b pc=%h ins=%h want 1/0/c0de0000",
               bus.out_valid, bus.out_pc, bus.out_instr);
    end
    repeat (8) step();
    checks++;
    if (grants.size() < 4 || got_pc.size() < 3) begin
      errors++;
      $display("FAIL stream_len: grants=%0d pops=%0d want >=4/>=3",
               grants.size(), got_pc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (grants[i] !== 32'(4 * i)) begin
          errors++;
          $display("FAIL stream_addr%0d: got %h want %h",
                   i, grants[i], 32'(4 * i));
        end
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_pc[i] !== 32'(4 * i)
            || got_ins[i] !== ins_of(32'(4 * i))) begin
          errors++;
          $display("FAIL stream_out%0d: pc=%h ins=%h want %h",
                   i, got_pc[i], got_ins[i], 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.dec_ready = 1'b0;
    repeat (12) step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0
        || bus.imem_req !== 1'b0 || grants.size() != 2) begin
      errors++;
      $display("FAIL bp_full: v=%b pc=%h req=%b grants=%0d want 1/0/0/2",
               bus.out_valid, bus.out_pc, bus.imem_req, grants.size());
    end
    bus.dec_ready = 1'b1;
    repeat (8) step();
    checks++;
    if (got_pc.size() < 3 || grants.size() < 3) begin
      errors++;
      $display("FAIL bp_drain_len: pops=%0d grants=%0d want >=3",
               got_pc.size(), grants.size());
    end else begin
      checks++;
      if (got_pc[0] !== 32'h0 || got_pc[1] !== 32'h4
          || got_pc[2] !== 32'h8 || got_ins[1] !== 32'hC0DE0004) begin
        errors++;
        $display("FAIL bp_order: %h %h %h ins1=%h want 0 4 8 c0de0004",
                 got_pc[0], got_pc[1], got_pc[2], got_ins[1]);
      end
      checks++;
      if (grants[2] !== 32'h8) begin
        errors++;
        $display("FAIL bp_resume: got %h want 8", grants[2]);
      end
    end
  endtask

  task automatic test_jump_wait();
    logic found;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.imem_req && bus.imem_addr == 32'h8) begin
        found = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL jw_timeout: req for 8 got none want one");
    end
    bus.dec_ready = 1'b0;
    stall_rsp = 1'b1;
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h4) begin
      errors++;
      $display("FAIL jw_pre: v=%b pc=%h want 1/4",
               bus.out_valid, bus.out_pc);
    end
    bus.jump_valid = 1'b1;
    bus.jump_addr  = 32'h40;
    step();
    bus.jump_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL jw_flush: v=%b req=%b want 0/0",
               bus.out_valid, bus.imem_req);
    end
    stall_rsp = 1'b0;
    step();
    checks++;
    if (bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL jw_drain: req=%b want 0", bus.imem_req);
    end
    step();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40
        || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL jw_target: req=%b addr=%h v=%b want 1/40/0",
               bus.imem_req, bus.imem_addr, bus.out_valid);
    end
    bus.dec_ready = 1'b1;
    step();
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h40
        || bus.out_instr !== 32'hC0DE0040) begin
      errors++;
      $display("FAIL jw_out: v=%b pc=%h ins=%h want 1/40/c0de0040",
               bus.out_valid, bus.out_pc, bus.out_instr);
    end
  endtask

  task automatic test_priority();
    do_reset();
    step();
    bus.branch_valid = 1'b1;
    bus.branch_addr  = 32'h100;
    bus.jump_valid   = 1'b1;
    bus.jump_addr    = 32'h200;
    step();
    bus.branch_valid = 1'b0;
    bus.jump_valid   = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL pri_drain: req=%b want 0", bus.imem_req);
    end
    step();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100
        || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pri_target: req=%b addr=%h v=%b want 1/100/0",
               bus.imem_req, bus.imem_addr, bus.out_valid);
    end
  endtask

  task automatic test_redirect_rvalid();
    do_reset();
    step();
    step();
    bus.jump_valid = 1'b1;
    bus.jump_addr  = 32'h82;
    step();
    bus.jump_valid = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h80
        || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rr_next: req=%b addr=%h v=%b want 1/80/0",
               bus.imem_req, bus.imem_addr, bus.out_valid);
    end
    step();
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h80
        || bus.out_instr !== 32'hC0DE0080) begin
      errors++;
      $display("FAIL rr_out: v=%b pc=%h ins=%h want 1/80/c0de0080",
               bus.out_valid, bus.out_pc, bus.out_instr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    step();
    bus.imem_gnt   = 1'b0;
    bus.jump_valid = 1'b1;
    bus.jump_addr  = 32'hFFFF_FFFC;
    step();
    bus.imem_gnt   = 1'b1;
    bus.jump_valid = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_req: req=%b addr=%h want 1/fffffffc",
               bus.imem_req, bus.imem_addr);
    end
    step();
    step();
    checks++;
    if (bus.out_pc !== 32'hFFFF_FFFC || bus.out_instr !== 32'hC0DEFFFC
        || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_pc: pc=%h ins=%h req=%b addr=%h want fffffffc/c0defffc/1/0",
               bus.out_pc, bus.out_instr, bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    bus.dec_ready = 1'b0;
    repeat (3) step();
    stall_rsp = 1'b1;
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL rmw_pre: v=%b req=%b want 1/0",
               bus.out_valid, bus.imem_req);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0
        || bus.out_instr !== 32'h0 || bus.imem_req !== 1'b0
        || bus.imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rmw_async: v=%b pc=%h ins=%h req=%b addr=%h want 0",
               bus.out_valid, bus.out_pc, bus.out_instr,
               bus.imem_req, bus.imem_addr);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stall_rsp = 1'b0;
    step();
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmw_late: v=%b pc=%h want 0",
               bus.out_valid, bus.out_pc);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0
        || bus.out_instr !== 32'hC0DE0000) begin
      errors++;
      $display("FAIL rmw_restart: v=%b pc=%h ins=%h want 1/0/c0de0000",
               bus.out_valid, bus.out_pc, bus.out_instr);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_jump_wait();
    test_priority();
    test_redirect_rvalid();
    test_wrap();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Front end of the pipeline; produces the (pc, instruction) stream that the decode stage consumes.
- Owns the fetch PC and issues single-outstanding word requests to instruction memory (req/gnt, then rvalid).
- Buffers returned words in a small FIFO and presents the head to decode with a valid/ready handshake.
- Handles redirects from decode (jump) and memory stage (taken branch), including flush and discard of a stale in-flight response.

Parameters:
ADDR_SIZE, 32, PC/address width
INSTR_SIZE, 32, instruction width
QUEUE_DEPTH, 2, instruction FIFO entries (power of two, >=2)
RESET_PC, 32'h00000000, first fetch address after reset

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
imem_req  out  1  fetch request valid
imem_addr  out  ADDR_SIZE  fetch word address, bits [1:0] always 0
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response data valid (exactly one per granted request, >=1 cycle after gnt)
imem_rdata  in  INSTR_SIZE  response instruction word
out_valid  out  1  out_pc/out_instr hold a valid instruction
out_pc  out  ADDR_SIZE  PC of head instruction
out_instr  out  INSTR_SIZE  head instruction
dec_ready  in  1  decode accepts head this cycle (driven from decode we && !stall)
jump_valid  in  1  decode-stage jump redirect
jump_addr  in  ADDR_SIZE  jump target
branch_valid  in  1  memory-stage taken-branch redirect
branch_addr  in  ADDR_SIZE  branch target

Behaviour:
- Reset (reset=0, async): fetch_pc=RESET_PC, FIFO empty, state=REQ, imem_req=0, imem_addr=0, out_valid=0, out_pc=0, out_instr=0. imem_req first rises on the first clock edge after reset release.
- States: REQ, WAIT, DRAIN.
- REQ: imem_req=1, imem_addr=fetch_pc, only when count+0 < QUEUE_DEPTH (one slot must be free for the response); else imem_req=0. On imem_req&&imem_gnt -> WAIT.
- WAIT: imem_req=0. On imem_rvalid: push {fetch_pc, imem_rdata}, fetch_pc+=4 (mod 2^ADDR_SIZE, wraps 0xFFFFFFFC->0), -> REQ.
- DRAIN: imem_req=0. On imem_rvalid: discard data, -> REQ. fetch_pc already holds the redirect target.
- Outputs: out_valid = FIFO non-empty; out_pc/out_instr = head entry, 0 when empty. Pop when out_valid&&dec_ready. Push and pop in the same cycle leave count unchanged. Pop on an empty FIFO is ignored.
- Minimum latency: request granted in cycle N, rvalid in N+1 -> out_valid in N+2.
- Redirect: redirect = branch_valid||jump_valid; target = branch_addr if branch_valid, else jump_addr (branch is older and wins). Target [1:0] are forced to 0.
- On redirect (registered at the edge): FIFO flushed (count=0, no pop, no push that cycle), fetch_pc=target. Next state:
  - WAIT without rvalid this cycle, or REQ with gnt this cycle -> DRAIN.
  - WAIT with rvalid this cycle -> REQ; response dropped.
  - REQ without gnt -> REQ; the next request uses the new target.
  - DRAIN -> DRAIN; still one stale response pending.
- Redirect takes priority over dec_ready. An instruction presented in the redirect cycle is treated as not consumed by fetch. Decode is responsible for squashing it.
- imem_req/imem_addr are held stable until gnt unless a redirect occurs. A redirect changes imem_addr the next cycle.

Optional Feature:
FETCH_PERF_CNT_EN: adds outputs perf_fetched [31:0] (instructions pushed into the FIFO) and perf_redirects [31:0] (redirect cycles). Both reset to 0 and wrap at 2^32. Without the macro, these ports and counters do not exist.

Test Plan:
- Reset release, gnt always 1, rvalid 1 cycle after gnt, dec_ready=1 -> imem_addr 0,4,8,...; out_pc 0,4,8 each paired with the matching rdata; first out_valid 3 cycles after reset release.
- dec_ready=0 held -> exactly QUEUE_DEPTH=2 words buffered (pc 0,4); imem_req stays 0 afterwards; raising dec_ready drains pc 0 then 4, then fetch resumes at 8.
- jump_valid=1, jump_addr=0x40 while in WAIT for addr 8 -> FIFO empties; rvalid for 8 is discarded; next imem_addr=0x40; out_pc=0x40 follows.
- branch_valid (0x100) and jump_valid (0x200) in the same cycle -> next fetch at 0x100.
- Redirect in the same cycle as rvalid -> word dropped, no DRAIN; next imem_addr=target.
- Assert reset mid-WAIT -> all outputs 0 immediately; fetch restarts at RESET_PC; a late rvalid after reset release is not pushed.
